// File: rtl/packet_word_packer.sv
// packet_word_packer: byte-to-word upsizer on the write side of the packet
// buffer. Bytes are packed LSB-first (first byte in lane [7:0]) into
// OUT_WIDTH-bit words. A word is emitted when its last lane fills or when
// the packet ends, and partial words carry zeros in their unused lanes.
// One accumulator plus one output register let a completed word wait in
// the accumulator (HOLD) while the output register is stalled downstream.
//
// Optional feature macro: PACKET_WORD_PACKER_BYTE_COUNT_EN
//   Adds m_pkt_bytes_o[15:0]. It carries the saturating byte total of the
//   packet and is meaningful when m_valid_o & m_last_o.
module packet_word_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 64,
    parameter int LANES     = OUT_WIDTH / IN_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [IN_WIDTH-1:0]  s_data_i,
    input  logic                 s_last_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [OUT_WIDTH-1:0] m_data_o,
    output logic [LANES-1:0]     m_keep_o,
    output logic                 m_last_o
`ifdef PACKET_WORD_PACKER_BYTE_COUNT_EN
    ,
    output logic [15:0]          m_pkt_bytes_o
`endif
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q;
    logic                 sReady_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [OUT_WIDTH-1:0] accData_q;
    logic [LANES-1:0]     accKeep_q;
    logic                 accLast_q;
    logic                 mValid_q;
    logic [OUT_WIDTH-1:0] mData_q;
    logic [LANES-1:0]     mKeep_q;
    logic                 mLast_q;

    logic [OUT_WIDTH-1:0] mergedData_d;
    logic [LANES-1:0]     mergedKeep_d;
    logic                 byteAccept_d;
    logic                 wordDone_d;
    logic                 outFree_d;

    // Accumulator contents with the incoming byte merged into its lane,
    // plus the handshake decisions shared by the FSM and the byte counter.
    always_comb begin
        mergedData_d = accData_q;
        mergedData_d[int'(cnt_q)*IN_WIDTH +: IN_WIDTH] = s_data_i;
        mergedKeep_d = accKeep_q | (LANES'(1) << cnt_q);
        byteAccept_d = s_valid_i & sReady_q & (state_q == FILL);
        wordDone_d   = byteAccept_d & (s_last_i | (cnt_q == CNT_W'(LANES - 1)));
        outFree_d    = ~mValid_q | m_ready_i;
    end

    // Packing FSM: FILL collects bytes and hands finished words to the
    // output register; HOLD parks one finished word until downstream drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= FILL;
            sReady_q  <= 1'b0;
            cnt_q     <= '0;
            accData_q <= '0;
            accKeep_q <= '0;
            accLast_q <= 1'b0;
            mValid_q  <= 1'b0;
            mData_q   <= '0;
            mKeep_q   <= '0;
            mLast_q   <= 1'b0;
        end else begin
            if (mValid_q && m_ready_i) begin
                mValid_q <= 1'b0;
            end
            case (state_q)
                FILL: begin
                    sReady_q <= 1'b1;
                    if (byteAccept_d) begin
                        if (wordDone_d) begin
                            cnt_q <= '0;
                            if (outFree_d) begin
                                mData_q   <= mergedData_d;
                                mKeep_q   <= mergedKeep_d;
                                mLast_q   <= s_last_i;
                                mValid_q  <= 1'b1;
                                accData_q <= '0;
                                accKeep_q <= '0;
                                accLast_q <= 1'b0;
                            end else begin
                                accData_q <= mergedData_d;
                                accKeep_q <= mergedKeep_d;
                                accLast_q <= s_last_i;
                                state_q   <= HOLD;
                                sReady_q  <= 1'b0;
                            end
                        end else begin
                            accData_q <= mergedData_d;
                            accKeep_q <= mergedKeep_d;
                            cnt_q     <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (m_ready_i) begin
                        mData_q   <= accData_q;
                        mKeep_q   <= accKeep_q;
                        mLast_q   <= accLast_q;
                        mValid_q  <= 1'b1;
                        accData_q <= '0;
                        accKeep_q <= '0;
                        accLast_q <= 1'b0;
                        state_q   <= FILL;
                        sReady_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign s_ready_o = sReady_q;
    assign m_valid_o = mValid_q;
    assign m_data_o  = mData_q;
    assign m_keep_o  = mKeep_q;
    assign m_last_o  = mLast_q;

`ifdef PACKET_WORD_PACKER_BYTE_COUNT_EN
    logic [15:0] runCount_q;
    logic [15:0] holdBytes_q;
    logic [15:0] pktBytes_q;
    logic [15:0] runNext_d;

    // Saturating increment of the running packet byte count.
    always_comb begin
        runNext_d = (runCount_q == 16'hFFFF) ? 16'hFFFF : runCount_q + 16'd1;
    end

    // Byte totals follow their word: into the output register directly,
    // or parked alongside the held word; cleared once a last word drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            runCount_q  <= '0;
            holdBytes_q <= '0;
            pktBytes_q  <= '0;
        end else begin
            if (byteAccept_d) begin
                runCount_q <= s_last_i ? 16'd0 : runNext_d;
            end
            if (wordDone_d && !outFree_d) begin
                holdBytes_q <= s_last_i ? runNext_d : 16'd0;
            end
            if (wordDone_d && outFree_d) begin
                pktBytes_q <= s_last_i ? runNext_d : 16'd0;
            end else if (state_q == HOLD && m_ready_i) begin
                pktBytes_q <= holdBytes_q;
            end else if (mValid_q && m_ready_i) begin
                pktBytes_q <= '0;
            end
        end
    end

    assign m_pkt_bytes_o = pktBytes_q;
`endif

endmodule

// File: tb/tb_packet_word_packer.sv
// tb_packet_word_packer: directed and randomized checks of the byte-to-word
// packer against a queue-based reference model of the packing rules.
module tb_packet_word_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sValid = 1'b0;
   logic        sReady;
   logic [7:0]  sData = '0;
   logic        sLast = 1'b0;
   logic        mValid;
   logic        mReady = 1'b0;
   logic [63:0] mData;
   logic [7:0]  mKeep;
   logic        mLast;
   logic [15:0] mPktBytes;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      int          bytes;
   } word_t;

   word_t      expQ[$];
   logic [7:0] curBytes[$];
   int         pktCnt = 0;
   int         compareCount = 0;
   int         mismatchCount = 0;
   logic       accepted;
   logic       wasStalled = 1'b0;
   logic [63:0] stalledData;
   logic [7:0]  stalledKeep;
   logic        stalledLast;

   packet_word_packer dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .s_valid_i (sValid),
      .s_ready_o (sReady),
      .s_data_i  (sData),
      .s_last_i  (sLast),
      .m_valid_o (mValid),
      .m_ready_i (mReady),
      .m_data_o  (mData),
      .m_keep_o  (mKeep),
      .m_last_o  (mLast)
`ifdef PACKET_WORD_PACKER_BYTE_COUNT_EN
      ,
      .m_pkt_bytes_o (mPktBytes)
`endif
   );

`ifndef PACKET_WORD_PACKER_BYTE_COUNT_EN
   assign mPktBytes = 16'd0;
`endif

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference model: bytes of a packet are grouped eight at a time, the
   // final group closing early on last; byte i of a group sits at bits 8i.
   task automatic modelPush(input logic [7:0] d, input logic l);
      word_t w;
      curBytes.push_back(d);
      if (pktCnt < 65535) pktCnt++;
      if (curBytes.size() == 8 || l) begin
         w.data = '0;
         for (int i = 0; i < curBytes.size(); i++) w.data[i*8 +: 8] = curBytes[i];
         w.keep = 8'((16'd1 << curBytes.size()) - 16'd1);
         w.last = l;
         w.bytes = l ? pktCnt : 0;
         if (l) pktCnt = 0;
         curBytes.delete();
         expQ.push_back(w);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, then check and
   // record both handshakes before the next rising edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic r);
      word_t w;
      @(negedge clk);
      sValid = v;
      sData  = d;
      sLast  = l;
      mReady = r;
      #1;
      checkOutput("mValidVsModel", 64'(mValid), 64'(expQ.size() != 0));
      checkOutput("sReadyVsModel", 64'(sReady), 64'(expQ.size() < 2));
      if (wasStalled && mValid) begin
         checkOutput("stableData", mData, stalledData);
         checkOutput("stableKeep", 64'(mKeep), 64'(stalledKeep));
         checkOutput("stableLast", 64'(mLast), 64'(stalledLast));
      end
      wasStalled  = mValid && !mReady;
      stalledData = mData;
      stalledKeep = mKeep;
      stalledLast = mLast;
      if (mValid && mReady && expQ.size() != 0) begin
         w = expQ.pop_front();
         checkOutput("wordData", mData, w.data);
         checkOutput("wordKeep", 64'(mKeep), 64'(w.keep));
         checkOutput("wordLast", 64'(mLast), 64'(w.last));
`ifdef PACKET_WORD_PACKER_BYTE_COUNT_EN
         if (w.last) checkOutput("pktBytes", 64'(mPktBytes), 64'(w.bytes));
`endif
      end
      accepted = v && sReady;
      if (accepted) modelPush(d, l);
   endtask

   // Compare the word currently presented without advancing time.
   task automatic peekWord(input string tag, input logic [63:0] d, input logic [7:0] k, input logic l);
      checkOutput({tag, "_valid"}, 64'(mValid), 64'd1);
      checkOutput({tag, "_data"}, mData, d);
      checkOutput({tag, "_keep"}, 64'(mKeep), 64'(k));
      checkOutput({tag, "_last"}, 64'(mLast), 64'(l));
   endtask

   task automatic drain();
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock.
   task automatic applyReset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rstValid", 64'(mValid), 64'd0);
      checkOutput("rstData", mData, 64'd0);
      checkOutput("rstKeep", 64'(mKeep), 64'd0);
      checkOutput("rstLast", 64'(mLast), 64'd0);
      checkOutput("rstReady", 64'(sReady), 64'd0);
      expQ.delete();
      curBytes.delete();
      pktCnt = 0;
      wasStalled = 1'b0;
      sValid = 1'b0;
      sLast  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      int idx;
      applyReset();

      // Sixteen bytes 0x00..0x0F in one packet.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      peekWord("seq16w0", 64'h0706050403020100, 8'hFF, 1'b0);
      for (int i = 8; i < 16; i++) applyStimulus(1'b1, 8'(i), i == 15, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      peekWord("seq16w1", 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1);
      drain();

      // Three-byte packet.
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'hCC, 1'b1, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      peekWord("short3", 64'h0000000000CCBBAA, 8'h07, 1'b1);
`ifdef PACKET_WORD_PACKER_BYTE_COUNT_EN
      checkOutput("short3_bytes", 64'(mPktBytes), 64'd3);
`endif
      drain();

      // Stalled downstream while streaming 24 bytes, then release.
      idx = 0;
      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'b1, 8'(8'h40 + idx), idx == 23, 1'b0);
         if (accepted) idx++;
      end
      checkOutput("stallAccepted", 64'(idx), 64'd16);
      checkOutput("stallReadyLow", 64'(sReady), 64'd0);
      for (int i = 0; i < 20 && idx < 24; i++) begin
         applyStimulus(1'b1, 8'(8'h40 + idx), idx == 23, 1'b1);
         if (accepted) idx++;
      end
      drain();

      // One-byte packets back to back.
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b1, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      peekWord("single", 64'h0000000000000093, 8'h01, 1'b1);
      drain();

      // Reset in the middle of a packet, then a clean 8-byte packet.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b1);
      applyReset();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h10 + 8'(i), i == 7, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      peekWord("afterRst", 64'h1716151413121110, 8'hFF, 1'b1);
      drain();

      // Randomized traffic and backpressure.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 2,
                       $urandom_range(0, 9) < 6);
      end
      drain();

`ifdef PACKET_WORD_PACKER_BYTE_COUNT_EN
      // Long packet: byte total saturates.
      for (int i = 0; i < 70000; i++) applyStimulus(1'b1, 8'(i), i == 69999, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("satLast", 64'(mLast), 64'd1);
      checkOutput("satBytes", 64'(mPktBytes), 64'hFFFF);
      drain();
`endif

      checkOutput("finalEmpty", 64'(mValid), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
